// File: rtl/store_rmw_queue.sv
// Buffered sub-word store engine. Stores are queued in a DEPTH-entry FIFO and
// retired in order against a word-only memory. Full-word stores are written
// directly; partial stores do read, merge, then write.
module store_rmw_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int SZ_W   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_data,
    input  logic [SZ_W-1:0]            req_size,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic                       mem_gnt,
    input  logic                       mem_rvalid,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err_misalign
);
    localparam int NB = DATA_W / 8;
    localparam int BW = $clog2(NB);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WRITE} state_e;

    // Sizes at or above the word size all mean a full-word store.
    function automatic int eff_size(input logic [SZ_W-1:0] sz);
        return (int'(sz) >= BW) ? BW : int'(sz);
    endfunction

    function automatic logic misaligned(input logic [ADDR_W-1:0] a, input logic [SZ_W-1:0] sz);
        int s;
        s = eff_size(sz);
        return (int'(a[BW-1:0]) & ((1 << s) - 1)) != 0;
    endfunction

    // Replace the addressed lane of the old word with the right-aligned store data.
    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                 input logic [DATA_W-1:0] d,
                                                 input logic [ADDR_W-1:0] a,
                                                 input logic [SZ_W-1:0]   sz);
        int s;
        int o;
        logic [DATA_W-1:0] m;
        s = eff_size(sz);
        o = int'(a[BW-1:0]) >> s;
        m = old;
        for (int b = 0; b < NB; b++) begin
            if ((b >> s) == o) m[8*b +: 8] = d[8*(b & ((1 << s) - 1)) +: 8];
        end
        return m;
    endfunction

    logic [ADDR_W-1:0] q_addr_q [DEPTH];
    logic [DATA_W-1:0] q_data_q [DEPTH];
    logic [SZ_W-1:0]   q_size_q [DEPTH];
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     count_q;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [SZ_W-1:0]   w_size_q, w_size_d;
    logic              err_q;
    logic              accept, push, pop, bad;

    assign req_ready    = (count_q != CW'(DEPTH));
    assign accept       = req_valid & req_ready;
    assign bad          = misaligned(req_addr, req_size);
    assign push         = accept & ~bad;
    assign pop          = (state_q == IDLE) & (count_q != '0);
    assign busy         = (count_q != '0) | (state_q != IDLE);
    assign count        = count_q;
    assign err_misalign = err_q;
    assign mem_addr     = {w_addr_q[ADDR_W-1:BW], {BW{1'b0}}};
    assign mem_wdata    = (state_q == WRITE) ? w_data_q : '0;

    // Queue storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr_q[wptr_q] <= req_addr;
            q_data_q[wptr_q] <= req_data;
            q_size_q[wptr_q] <= req_size;
        end
    end

    // Queue pointers, occupancy and the misalignment pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept & bad;
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FSM state and working store register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            w_addr_q <= '0;
            w_data_q <= '0;
            w_size_q <= '0;
        end else begin
            state_q  <= state_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            w_size_q <= w_size_d;
        end
    end

    // Next state and memory request decode; w_data holds store data until merged.
    always_comb begin
        state_d  = state_q;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        w_size_d = w_size_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    w_addr_d = q_addr_q[rptr_q];
                    w_data_d = q_data_q[rptr_q];
                    w_size_d = q_size_q[rptr_q];
                    state_d  = (eff_size(q_size_q[rptr_q]) == BW) ? WRITE : RD_REQ;
                end
            end
            RD_REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rvalid) begin
                    w_data_d = merge(mem_rdata, w_data_q, w_addr_q, w_size_q);
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_gnt) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_store_rmw_queue.sv
// Scoreboard bench: the driver pushes expected memory transactions computed by
// a byte-mask reference model; a monitor pops them at every memory grant.
module tb_store_rmw_queue;
    logic        clk, rst_n;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_data;
    logic [1:0]  req_size;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy, err_misalign;
    logic [2:0]  count;

    store_rmw_queue dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_data(req_data), .req_size(req_size),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .count(count), .err_misalign(err_misalign)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        expq[$];
    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int          checks = 0, errors = 0;
    int          gnt_mode = 1, rd_lat = 1;
    int          err_exp = 0, err_seen = 0;
    logic [31:0] last_wdata = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] env_rd(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // Reference: the store covers 2^s bytes starting at byte addr%4 of the word.
    task automatic model(input logic [31:0] a, input logic [31:0] d, input int sz);
        int          s, nbytes, off;
        logic [63:0] mask, ins;
        logic [31:0] wa, old, nw;
        s      = (sz > 2) ? 2 : sz;
        nbytes = 1 << s;
        off    = int'(a % 4);
        wa     = a & ~32'h3;
        if ((a % nbytes) != 0) begin
            err_exp++;
        end else if (nbytes == 4) begin
            expq.push_back('{1'b1, wa, d});
            ref_mem[wa] = d;
        end else begin
            old  = ref_rd(wa);
            mask = ((64'd1 << (8 * nbytes)) - 64'd1) << (8 * off);
            ins  = {32'h0, d} << (8 * off);
            nw   = (old & ~mask[31:0]) | (ins[31:0] & mask[31:0]);
            expq.push_back('{1'b0, wa, 32'h0});
            expq.push_back('{1'b1, wa, nw});
            ref_mem[wa] = nw;
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic send(input logic [31:0] a, input logic [31:0] d, input int sz);
        int n = 0;
        req_valid = 1'b1; req_addr = a; req_data = d; req_size = 2'(sz);
        while (!req_ready && n < 300) begin @(negedge clk); n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: req_ready stuck at 0 for addr %h", a);
            req_valid = 1'b0;
            return;
        end
        model(a, d, sz);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || expq.size() != 0) && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) begin
            checks++; errors++;
            $display("FAIL wait_idle: timeout busy=%0b pending=%0d", busy, expq.size());
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_err", 32'(err_misalign), 32'd0);
    endtask

    // Memory model: grant policy, read latency, and committed writes.
    initial begin
        int          rd_cnt = 0;
        logic [31:0] rd_addr = 0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        forever begin
            @(posedge clk); #2;
            mem_rvalid = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin mem_rvalid = 1'b1; mem_rdata = env_rd(rd_addr); end
            end
            case (gnt_mode)
                0: mem_gnt = 1'b0;
                1: mem_gnt = 1'b1;
                2: mem_gnt = 1'($urandom_range(0, 1));
                default: begin mem_gnt = mem_req; if (mem_req) gnt_mode = 0; end
            endcase
            if (mem_req && mem_gnt) begin
                if (mem_we) env_mem[mem_addr] = mem_wdata;
                else begin
                    rd_cnt  = (rd_lat == 0) ? int'($urandom_range(1, 3)) : rd_lat;
                    rd_addr = mem_addr;
                end
            end
        end
    end

    // Monitor: pop and compare at every grant; check stall stability.
    initial begin
        logic        stall_v = 1'b0, p_we = 1'b0;
        logic [31:0] p_addr = 0, p_wdata = 0;
        txn_t        t;
        forever begin
            @(negedge clk); #1;
            if (!rst_n) begin stall_v = 1'b0; continue; end
            if (stall_v && mem_req) begin
                chk("stable_addr", mem_addr, p_addr);
                chk("stable_we", 32'(mem_we), 32'(p_we));
                if (p_we) chk("stable_wdata", mem_wdata, p_wdata);
            end
            if (mem_req && mem_gnt) begin
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: we=%0b addr=%h wdata=%h, none expected",
                             mem_we, mem_addr, mem_wdata);
                end else begin
                    t = expq.pop_front();
                    chk("mem_we", 32'(mem_we), 32'(t.we));
                    chk("mem_addr", mem_addr, t.addr);
                    if (t.we) begin
                        chk("mem_wdata", mem_wdata, t.data);
                        last_wdata = mem_wdata;
                    end
                end
            end
            stall_v = mem_req && !mem_gnt;
            p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
            if (err_misalign) err_seen++;
        end
    end

    initial begin
        logic [2:0] c0;
        int         n;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 0; req_data = 0; req_size = 0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;

        // Full-word store: write only.
        send(32'h10, 32'hDEADBEEF, 2);
        wait_idle();
        chk("word_wdata", last_wdata, 32'hDEADBEEF);
        chk("word_busy_low", 32'(busy), 32'd0);

        // Byte and half read-merge-write against a known word.
        env_mem[32'h10] = 32'h11223344; ref_mem[32'h10] = 32'h11223344;
        send(32'h13, 32'h000000AB, 0);
        wait_idle();
        chk("byte_merge", last_wdata, 32'hAB223344);
        env_mem[32'h10] = 32'h11223344; ref_mem[32'h10] = 32'h11223344;
        send(32'h12, 32'h0000CAFE, 1);
        wait_idle();
        chk("half_merge", last_wdata, 32'hCAFE3344);

        // Fill with grants withheld: one store in flight plus four queued.
        gnt_mode = 0;
        for (int i = 0; i < 5; i++) send(32'h100 + 32'(4 * i), 32'hA0000000 + 32'(i), 2);
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(req_ready), 32'd0);
        repeat (3) @(negedge clk);
        gnt_mode = 3;
        repeat (4) @(negedge clk);
        chk("drain_count", 32'(count), 32'd3);
        gnt_mode = 1;
        wait_idle();
        chk("drain_empty", 32'(count), 32'd0);

        // Back-to-back bytes to the same word: second merge sees the first write.
        env_mem[32'h20] = 32'h0; ref_mem[32'h20] = 32'h0;
        send(32'h20, 32'h01, 0);
        send(32'h21, 32'h02, 0);
        wait_idle();
        chk("b2b_merge", last_wdata, 32'h00000201);

        // Misaligned half store is dropped with a one-cycle error pulse.
        c0 = count;
        send(32'h21, 32'h1234, 1);
        chk("misalign_pulse", 32'(err_misalign), 32'd1);
        @(negedge clk);
        chk("misalign_pulse_end", 32'(err_misalign), 32'd0);
        chk("misalign_count", 32'(count), 32'(c0));
        chk("misalign_no_req", 32'(mem_req), 32'd0);

        // Reset while waiting on read data, with two stores queued.
        gnt_mode = 0; rd_lat = 4;
        send(32'h30, 32'h11, 0);
        send(32'h34, 32'h2222, 1);
        send(32'h38, 32'h33, 0);
        gnt_mode = 3;
        n = 0;
        while (mem_req && n < 20) begin @(negedge clk); n++; end
        chk("rdwait_reached", 32'(mem_req), 32'd0);
        chk("rdwait_count", 32'(count), 32'd2);
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        expq.delete();
        ref_mem = env_mem;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_no_req", 32'(mem_req), 32'd0);
        end
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Randomized traffic in a small window to create same-word hazards.
        gnt_mode = 2; rd_lat = 0;
        for (int i = 0; i < 60; i++) begin
            send(32'h40 + 32'($urandom_range(0, 15)), $urandom, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        gnt_mode = 1;
        wait_idle();
        chk("final_pending", 32'(expq.size()), 32'd0);
        chk("err_pulses", 32'(err_seen), 32'(err_exp));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
